// File: rtl/ivector_arbiter.sv
// Two-requester round-robin front end for one IVector say/heard pair; a tag FIFO routes replies back in issue order.
// Optional per-requester forward counters (stat0/stat1) are built when IVECTOR_ARB_STATS_EN is defined.
module ivector_arbiter #(
    parameter int TAG_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0_say__ENA,
    input  logic [95:0] req0_say_v,
    output logic        req0_say__RDY,
    input  logic        req1_say__ENA,
    input  logic [95:0] req1_say_v,
    output logic        req1_say__RDY,
    output logic        out_say__ENA,
    output logic [95:0] out_say_v,
    input  logic        out_say__RDY,
    input  logic        ind_heard__ENA,
    input  logic [95:0] ind_heard_v,
    output logic        ind_heard__RDY,
    output logic        ind0_heard__ENA,
    output logic [95:0] ind0_heard_v,
    input  logic        ind0_heard__RDY,
    output logic        ind1_heard__ENA,
    output logic [95:0] ind1_heard_v,
    input  logic        ind1_heard__RDY
`ifdef IVECTOR_ARB_STATS_EN
    ,
    output logic [31:0] stat0,
    output logic [31:0] stat1
`endif
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [CNT_W-1:0] TAG_FULL = CNT_W'(TAG_DEPTH);

    logic [1:0]       buf_valid_reg;
    logic [95:0]      buf_data_reg [2];
    logic             last_reg;
    logic             tag_mem_reg [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] tag_count_reg;

    logic [1:0]  say_ena;
    logic [1:0]  say_rdy;
    logic [1:0]  say_xfer;
    logic [95:0] say_data [2];
    logic        sel;
    logic        fwd;
    logic        head;
    logic        heard_rdy;
    logic        heard_xfer;

    assign say_ena     = {req1_say__ENA, req0_say__ENA};
    assign say_data[0] = req0_say_v;
    assign say_data[1] = req1_say_v;

    // On a tie the requester that did not win last time goes next.
    assign sel  = (&buf_valid_reg) ? ~last_reg : buf_valid_reg[1];
    assign fwd  = nRST && (|buf_valid_reg) && out_say__RDY && (tag_count_reg != TAG_FULL);
    assign head = tag_mem_reg[rd_ptr_reg];

    assign heard_rdy  = nRST && (tag_count_reg != '0) && (head ? ind1_heard__RDY : ind0_heard__RDY);
    assign heard_xfer = ind_heard__ENA && heard_rdy;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            assign say_rdy[gi]  = nRST && (!buf_valid_reg[gi] || (fwd && (sel == 1'(gi))));
            assign say_xfer[gi] = say_ena[gi] && say_rdy[gi];

            // A refill in the same cycle as a forward keeps the buffer valid.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    buf_valid_reg[gi] <= 1'b0;
                end else if (say_xfer[gi]) begin
                    buf_valid_reg[gi] <= 1'b1;
                    buf_data_reg[gi]  <= say_data[gi];
                end else if (fwd && (sel == 1'(gi))) begin
                    buf_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (fwd) begin
            tag_mem_reg[wr_ptr_reg] <= sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            tag_count_reg <= '0;
            last_reg      <= 1'b1;
        end else begin
            if (fwd) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                last_reg   <= sel;
            end
            if (heard_xfer) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({fwd, heard_xfer})
                2'b10:   tag_count_reg <= tag_count_reg + CNT_W'(1);
                2'b01:   tag_count_reg <= tag_count_reg - CNT_W'(1);
                default: tag_count_reg <= tag_count_reg;
            endcase
        end
    end

    assign req0_say__RDY   = say_rdy[0];
    assign req1_say__RDY   = say_rdy[1];
    assign out_say__ENA    = fwd;
    assign out_say_v       = nRST ? buf_data_reg[sel] : '0;
    assign ind_heard__RDY  = heard_rdy;
    assign ind0_heard__ENA = nRST && ind_heard__ENA && !head;
    assign ind1_heard__ENA = nRST && ind_heard__ENA && head;
    assign ind0_heard_v    = nRST ? ind_heard_v : '0;
    assign ind1_heard_v    = nRST ? ind_heard_v : '0;

`ifdef IVECTOR_ARB_STATS_EN
    logic [31:0] stat_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    stat_reg[gi] <= '0;
                end else if (fwd && (sel == 1'(gi))) begin
                    stat_reg[gi] <= stat_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign stat0 = nRST ? stat_reg[0] : '0;
    assign stat1 = nRST ? stat_reg[1] : '0;
`endif

endmodule

// File: tb/tb_ivector_arbiter.sv
// Randomized bench for ivector_arbiter checked cycle by cycle against a queue-based reference model.
module tb_ivector_arbiter;
    localparam int TAG_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        r0_ena, r0_rdy, r1_ena, r1_rdy;
    logic [95:0] r0_v, r1_v;
    logic        o_ena, o_rdy;
    logic [95:0] o_v;
    logic        i_ena, i_rdy, i0_ena, i0_rdy, i1_ena, i1_rdy;
    logic [95:0] i_v, i0_v, i1_v;
`ifdef IVECTOR_ARB_STATS_EN
    logic [31:0] stat0, stat1;
`endif

    ivector_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
        .CLK(CLK),
        .nRST(rst_n),
        .req0_say__ENA(r0_ena),
        .req0_say_v(r0_v),
        .req0_say__RDY(r0_rdy),
        .req1_say__ENA(r1_ena),
        .req1_say_v(r1_v),
        .req1_say__RDY(r1_rdy),
        .out_say__ENA(o_ena),
        .out_say_v(o_v),
        .out_say__RDY(o_rdy),
        .ind_heard__ENA(i_ena),
        .ind_heard_v(i_v),
        .ind_heard__RDY(i_rdy),
        .ind0_heard__ENA(i0_ena),
        .ind0_heard_v(i0_v),
        .ind0_heard__RDY(i0_rdy),
        .ind1_heard__ENA(i1_ena),
        .ind1_heard_v(i1_v),
        .ind1_heard__RDY(i1_rdy)
`ifdef IVECTOR_ARB_STATS_EN
        ,
        .stat0(stat0),
        .stat1(stat1)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending request per requester, outstanding owner tags, last winner.
    logic [95:0] bq0[$];
    logic [95:0] bq1[$];
    bit          tags[$];
    int          m_last = 1;
    int unsigned m_stat [2] = '{0, 0};

    bit          e_fwd, e_sel, e_rdy0, e_rdy1, e_irdy, e_head;
    logic [95:0] e_fwd_v;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void model_eval(input logic ordy, input logic i0r, input logic i1r);
        bit v0, v1;
        v0      = bq0.size() != 0;
        v1      = bq1.size() != 0;
        e_sel   = (v0 && v1) ? (m_last == 0) : v1;
        e_fwd   = (v0 || v1) && ordy && (tags.size() < TAG_DEPTH);
        e_rdy0  = !v0 || (e_fwd && !e_sel);
        e_rdy1  = !v1 || (e_fwd && e_sel);
        e_head  = (tags.size() != 0) ? tags[0] : 1'b0;
        e_irdy  = (tags.size() != 0) && (e_head ? i1r : i0r);
        e_fwd_v = e_fwd ? (e_sel ? bq1[0] : bq0[0]) : '0;
    endfunction

    task automatic step(input logic rst_i, input logic r0e, input logic [95:0] r0v,
                        input logic r1e, input logic [95:0] r1v, input logic ordy,
                        input logic ie, input logic [95:0] iv, input logic i0r, input logic i1r);
        rst_n = rst_i; r0_ena = r0e; r0_v = r0v; r1_ena = r1e; r1_v = r1v;
        o_rdy = ordy; i_ena = ie; i_v = iv; i0_rdy = i0r; i1_rdy = i1r;
        model_eval(ordy, i0r, i1r);
        #1;
        if (!rst_i) begin
            check_val("rst_out_ena", o_ena, 0);
            check_val("rst_out_v", o_v, 0);
            check_val("rst_req0_rdy", r0_rdy, 0);
            check_val("rst_req1_rdy", r1_rdy, 0);
            check_val("rst_ind_rdy", i_rdy, 0);
            check_val("rst_ind0_ena", i0_ena, 0);
            check_val("rst_ind1_ena", i1_ena, 0);
            check_val("rst_ind0_v", i0_v, 0);
            check_val("rst_ind1_v", i1_v, 0);
        end else begin
            check_val("out_ena", o_ena, e_fwd);
            if (e_fwd) check_val("out_v", o_v, e_fwd_v);
            check_val("req0_rdy", r0_rdy, e_rdy0);
            check_val("req1_rdy", r1_rdy, e_rdy1);
            check_val("ind_rdy", i_rdy, e_irdy);
            check_val("ind0_ena", i0_ena, ie && !e_head);
            check_val("ind1_ena", i1_ena, ie && e_head);
            check_val("ind0_v", i0_v, iv);
            check_val("ind1_v", i1_v, iv);
`ifdef IVECTOR_ARB_STATS_EN
            check_val("stat0", stat0, m_stat[0]);
            check_val("stat1", stat1, m_stat[1]);
`endif
        end
        @(posedge CLK);
        if (!rst_i) begin
            bq0.delete(); bq1.delete(); tags.delete();
            m_last = 1; m_stat[0] = 0; m_stat[1] = 0;
        end else begin
            if (ie && e_irdy) begin
                $display("heard -> req%0d v=%h", tags[0], iv);
                void'(tags.pop_front());
            end
            if (e_fwd) begin
                $display("fwd   <- req%0d v=%h", e_sel, e_fwd_v);
                if (e_sel) void'(bq1.pop_front()); else void'(bq0.pop_front());
                tags.push_back(e_sel);
                m_last = e_sel;
                m_stat[e_sel]++;
            end
            if (r0e && e_rdy0) begin bq0.delete(); bq0.push_back(r0v); end
            if (r1e && e_rdy1) begin bq1.delete(); bq1.push_back(r1v); end
        end
        @(negedge CLK);
    endtask

    // Enables follow the model's RDY, with occasional deliberate protocol errors on the say ports.
    task automatic rand_step(input int p_ordy, input int p_req, input int p_ind, input int p_irdy);
        logic ordy, i0r, i1r, r0e, r1e, ie;
        ordy = ($urandom_range(99) < p_ordy);
        i0r  = ($urandom_range(99) < p_irdy);
        i1r  = ($urandom_range(99) < p_irdy);
        model_eval(ordy, i0r, i1r);
        r0e = e_rdy0 ? ($urandom_range(99) < p_req) : ($urandom_range(99) < 3);
        r1e = e_rdy1 ? ($urandom_range(99) < p_req) : ($urandom_range(99) < 3);
        ie  = e_irdy && ($urandom_range(99) < p_ind);
        step(1'b1, r0e, rnd96(), r1e, rnd96(), ordy, ie, rnd96(), i0r, i1r);
    endtask

    task automatic rst_steps(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, rnd96(), 1'b1, rnd96(), 1'b1, 1'b1, rnd96(), 1'b1, 1'b1);
    endtask

    initial begin
        rst_n = 0; r0_ena = 0; r1_ena = 0; o_rdy = 0; i_ena = 0;
        r0_v = '0; r1_v = '0; i_v = '0; i0_rdy = 0; i1_rdy = 0;
        @(negedge CLK);
        rst_steps(3);

        // Single requester: say {1,2,3}, forward next cycle, heard {4,5,6} back to req0.
        step(1, 1, {32'd3, 32'd2, 32'd1}, 0, '0, 1, 0, '0, 1, 1);
        step(1, 0, '0, 0, '0, 1, 0, '0, 1, 1);
        step(1, 0, '0, 0, '0, 1, 1, {32'd6, 32'd5, 32'd4}, 1, 1);

        // Contention with returns flowing.
        for (int i = 0; i < 10; i++) rand_step(100, 100, 100, 100);
        // Tag FIFO fills, then drains.
        for (int i = 0; i < 10; i++) rand_step(100, 100, 0, 100);
        for (int i = 0; i < 6; i++) rand_step(100, 100, 100, 100);
        // Head-of-line stall, then release.
        for (int i = 0; i < 8; i++) rand_step(100, 60, 100, 0);
        for (int i = 0; i < 8; i++) rand_step(100, 60, 100, 100);
        // Output backpressure with full buffers.
        for (int i = 0; i < 6; i++) rand_step(0, 100, 50, 100);
        for (int i = 0; i < 4; i++) rand_step(100, 100, 0, 100);
        // Reset mid-flight.
        rst_steps(2);
        for (int i = 0; i < 3; i++) rand_step(100, 100, 50, 100);

        for (int phase = 0; phase < 15; phase++) begin
            int p_o, p_r, p_i, p_ir;
            p_o  = $urandom_range(100);
            p_r  = $urandom_range(100);
            p_i  = $urandom_range(100);
            p_ir = $urandom_range(100);
            if ($urandom_range(3) == 0) rst_steps(1);
            for (int i = 0; i < 100; i++) rand_step(p_o, p_r, p_i, p_ir);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
